// File: rtl/entrada_bases_pkg.sv
// Shared constants for serial digit entry: base codes, radices, per-base digit limits, state encoding.
// Also imported by the optional ECO_DISPLAY_EN echo path and the ULA operand entry path.
package entrada_bases_pkg;

  localparam int unsigned DIGITO_W = 4;
  localparam int unsigned BASE_W   = 2;
  localparam int unsigned NUM_W    = 2;

  localparam logic [BASE_W-1:0] BASE_DEC = 2'b00;
  localparam logic [BASE_W-1:0] BASE_HEX = 2'b01;
  localparam logic [BASE_W-1:0] BASE_OCT = 2'b10;

  localparam int unsigned RADIX_DEC = 10;
  localparam int unsigned RADIX_HEX = 16;
  localparam int unsigned RADIX_OCT = 8;

  localparam int unsigned LIMITE_DEC = 3;
  localparam int unsigned LIMITE_HEX = 2;
  localparam int unsigned LIMITE_OCT = 3;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    COLETANDO = 2'b01,
    CONCLUIDO = 2'b10,
    ERRO      = 2'b11
  } estado_t;

  // Digit cap for a base, clipped to the global per-entry cap; reserved base allows none.
  function automatic logic [NUM_W-1:0] limite_digitos(input logic [BASE_W-1:0] base,
                                                      input int unsigned max_digitos);
    int unsigned lim;
    case (base)
      BASE_DEC: lim = LIMITE_DEC;
      BASE_HEX: lim = LIMITE_HEX;
      BASE_OCT: lim = LIMITE_OCT;
      default:  lim = 0;
    endcase
    if (lim > max_digitos) lim = max_digitos;
    return NUM_W'(lim);
  endfunction

  // Radix of a base; zero for the reserved code so no digit compares as valid.
  function automatic logic [DIGITO_W:0] radix_da_base(input logic [BASE_W-1:0] base);
    case (base)
      BASE_DEC: return (DIGITO_W+1)'(RADIX_DEC);
      BASE_HEX: return (DIGITO_W+1)'(RADIX_HEX);
      BASE_OCT: return (DIGITO_W+1)'(RADIX_OCT);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/entrada_bases_if.sv
// Digit-entry bus between keypad front end and entrada_bases.
// ECO_DISPLAY_EN adds the parcial echo of the accumulator.
interface entrada_bases_if
  import entrada_bases_pkg::*;
#(
  parameter int unsigned LARGURA = 8
);

  logic [DIGITO_W-1:0] digito;
  logic                digito_valido;
  logic [BASE_W-1:0]   base_selecionada;
  logic                confirmar;
  logic                limpar;
  logic [LARGURA-1:0]  valor_binario;
  logic                pronto;
  logic                erro;
  logic                ocupado;
  logic [NUM_W-1:0]    num_digitos;
`ifdef ECO_DISPLAY_EN
  logic [LARGURA-1:0]  parcial;

  modport master (
    output digito, digito_valido, base_selecionada, confirmar, limpar,
    input  valor_binario, pronto, erro, ocupado, num_digitos, parcial
  );
  modport slave (
    input  digito, digito_valido, base_selecionada, confirmar, limpar,
    output valor_binario, pronto, erro, ocupado, num_digitos, parcial
  );
`else
  modport master (
    output digito, digito_valido, base_selecionada, confirmar, limpar,
    input  valor_binario, pronto, erro, ocupado, num_digitos
  );
  modport slave (
    input  digito, digito_valido, base_selecionada, confirmar, limpar,
    output valor_binario, pronto, erro, ocupado, num_digitos
  );
`endif

endinterface

// File: rtl/entrada_bases_multiplicador_base.sv
// Combinational acc*base + digito with overflow and digit-valid flags.
// Shift/add multipliers only, evaluated LARGURA+4 bits wide so no carry is lost.
module multiplicador_base
  import entrada_bases_pkg::*;
#(
  parameter int unsigned LARGURA = 8
) (
  input  logic [LARGURA-1:0]  acc,
  input  logic [BASE_W-1:0]   base,
  input  logic [DIGITO_W-1:0] digito,
  output logic [LARGURA-1:0]  resultado_c,
  output logic                estouro_c,
  output logic                digito_ok_c
);

  localparam int unsigned EXT_W = LARGURA + 4;
  localparam logic [EXT_W-1:0] MAXIMO = {{4{1'b0}}, {LARGURA{1'b1}}};

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] produto;
  logic [EXT_W-1:0] soma;

  always_comb begin
    ext = EXT_W'(acc);
    case (base)
      BASE_DEC: produto = (ext << 3) + (ext << 1);
      BASE_HEX: produto = ext << 4;
      BASE_OCT: produto = ext << 3;
      default:  produto = '0;
    endcase
    soma        = produto + EXT_W'(digito);
    resultado_c = soma[LARGURA-1:0];
    estouro_c   = soma > MAXIMO;
    digito_ok_c = {1'b0, digito} < radix_da_base(base);
  end

endmodule

// File: rtl/entrada_bases.sv
// Serial digit-entry decoder: accumulates decimal/hex/octal digits into a LARGURA-bit value.
// Optional ECO_DISPLAY_EN exports the running accumulator as parcial.
module entrada_bases
  import entrada_bases_pkg::*;
#(
  parameter int unsigned LARGURA     = 8,
  parameter int unsigned MAX_DIGITOS = 3
) (
  input  logic            clk,
  input  logic            reset,
  entrada_bases_if.slave  bus
);

  estado_t             estado;
  logic [LARGURA-1:0]  acc;
  logic [BASE_W-1:0]   base_q;
  logic [NUM_W-1:0]    num_q;
  logic [LARGURA-1:0]  valor_q;
  logic                pronto_q;
  logic                erro_q;
  logic                ocupado_q;

  logic [LARGURA-1:0]  mul_acc;
  logic [BASE_W-1:0]   mul_base;
  logic [LARGURA-1:0]  resultado;
  logic                estouro;
  logic                digito_ok;
  logic                cheio;
  logic                aceita;

  // A new entry starts from zero with the live base; an ongoing one uses the latched base.
  assign mul_acc  = (estado == COLETANDO) ? acc : '0;
  assign mul_base = (estado == COLETANDO) ? base_q : bus.base_selecionada;
  assign cheio    = (estado == COLETANDO) && (num_q >= limite_digitos(mul_base, MAX_DIGITOS));
  assign aceita   = digito_ok && !estouro && !cheio;

  multiplicador_base #(.LARGURA(LARGURA)) u_mult (
    .acc         (mul_acc),
    .base        (mul_base),
    .digito      (bus.digito),
    .resultado_c (resultado),
    .estouro_c   (estouro),
    .digito_ok_c (digito_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= OCIOSO;
      acc       <= '0;
      base_q    <= BASE_DEC;
      num_q     <= '0;
      valor_q   <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      if (bus.limpar) begin
        estado    <= OCIOSO;
        acc       <= '0;
        num_q     <= '0;
        erro_q    <= 1'b0;
        ocupado_q <= 1'b0;
      end else begin
        case (estado)
          ERRO: begin
            // Locked until limpar; digits and confirmar are dropped.
            acc <= '0;
          end
          COLETANDO: begin
            if (bus.confirmar) begin
              valor_q   <= acc;
              pronto_q  <= 1'b1;
              estado    <= CONCLUIDO;
              acc       <= '0;
              num_q     <= '0;
              ocupado_q <= 1'b0;
            end else if (bus.digito_valido) begin
              if (aceita) begin
                acc   <= resultado;
                num_q <= num_q + NUM_W'(1);
              end else begin
                estado    <= ERRO;
                erro_q    <= 1'b1;
                acc       <= '0;
                num_q     <= '0;
                ocupado_q <= 1'b0;
              end
            end
          end
          default: begin
            // OCIOSO and CONCLUIDO behave alike: confirm publishes zero, a digit opens an entry.
            if (bus.confirmar) begin
              valor_q  <= '0;
              pronto_q <= 1'b1;
              estado   <= CONCLUIDO;
            end else if (bus.digito_valido) begin
              if (aceita) begin
                acc       <= resultado;
                num_q     <= NUM_W'(1);
                base_q    <= bus.base_selecionada;
                estado    <= COLETANDO;
                ocupado_q <= 1'b1;
              end else begin
                estado    <= ERRO;
                erro_q    <= 1'b1;
                acc       <= '0;
                num_q     <= '0;
                ocupado_q <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.valor_binario = valor_q;
  assign bus.pronto        = pronto_q;
  assign bus.erro          = erro_q;
  assign bus.ocupado       = ocupado_q;
  assign bus.num_digitos   = num_q;
`ifdef ECO_DISPLAY_EN
  assign bus.parcial       = acc;
`endif

endmodule

// File: tb/tb_entrada_bases.sv
// Bench for entrada_bases: directed plan scenarios plus random strobes against a behavioural model.
module tb_entrada_bases;

  localparam int unsigned LARGURA = 8;
  localparam int unsigned MAXD    = 3;
  localparam int          MAXVAL  = (1 << LARGURA) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  entrada_bases_if #(.LARGURA(LARGURA)) ifc ();

  entrada_bases #(.LARGURA(LARGURA), .MAX_DIGITOS(MAXD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int m_valor, m_acc, m_num, m_radix, m_lim;
  bit m_col, m_err, m_pronto;

  function automatic int radix_of(input logic [1:0] b);
    case (b)
      2'b00: return 10;
      2'b01: return 16;
      2'b10: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int lim_of(input logic [1:0] b);
    int l;
    case (b)
      2'b00: l = 3;
      2'b01: l = 2;
      2'b10: l = 3;
      default: l = 0;
    endcase
    return (l > MAXD) ? MAXD : l;
  endfunction

  always @(posedge clk) begin
    bit ok;
    m_pronto = 1'b0;
    if (reset) begin
      m_valor = 0; m_acc = 0; m_num = 0; m_col = 0; m_err = 0;
      m_radix = 10; m_lim = 3;
    end else if (ifc.limpar) begin
      m_col = 0; m_acc = 0; m_num = 0; m_err = 0;
    end else if (m_err) begin
      m_acc = 0;
    end else if (ifc.confirmar) begin
      m_valor  = m_col ? m_acc : 0;
      m_pronto = 1'b1;
      m_col = 0; m_acc = 0; m_num = 0;
    end else if (ifc.digito_valido) begin
      if (!m_col) begin
        m_radix = radix_of(ifc.base_selecionada);
        m_lim   = lim_of(ifc.base_selecionada);
      end
      ok = (m_radix != 0) && (int'(ifc.digito) < m_radix) && (m_num < m_lim)
           && (m_acc * m_radix + int'(ifc.digito) <= MAXVAL);
      if (ok) begin
        m_acc = m_acc * m_radix + int'(ifc.digito);
        m_num = m_num + 1;
        m_col = 1;
      end else begin
        m_err = 1; m_col = 0; m_acc = 0; m_num = 0;
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("valor_binario", 32'(ifc.valor_binario), 32'(m_valor));
    chk("pronto",        32'(ifc.pronto),        32'(m_pronto));
    chk("erro",          32'(ifc.erro),          32'(m_err));
    chk("ocupado",       32'(ifc.ocupado),       32'(m_col));
    chk("num_digitos",   32'(ifc.num_digitos),   32'(m_num));
`ifdef ECO_DISPLAY_EN
    chk("parcial",       32'(ifc.parcial),       32'(m_acc));
`endif
  end

  task automatic ciclo(input bit l, input bit c, input bit v, input logic [3:0] d, input logic [1:0] b);
    ifc.limpar           = l;
    ifc.confirmar        = c;
    ifc.digito_valido    = v;
    ifc.digito           = d;
    ifc.base_selecionada = b;
    @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] d, input logic [1:0] b);
    ciclo(1'b0, 1'b0, 1'b1, d, b);
  endtask

  task automatic conf();
    ciclo(1'b0, 1'b1, 1'b0, 4'd0, 2'b00);
  endtask

  task automatic limpa();
    ciclo(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
  endtask

  task automatic ocioso();
    ciclo(1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ciclo(1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
    ocioso();
    chk("reset valor", 32'(ifc.valor_binario), 32'd0);
    chk("reset erro",  32'(ifc.erro), 32'd0);
    reset = 1'b0;
    ocioso();

    // Decimal 255
    dig(4'd2, 2'b00);
    chk("dec ocupado", 32'(ifc.ocupado), 32'd1);
    dig(4'd5, 2'b00); dig(4'd5, 2'b00);
    conf();
    chk("dec 255 valor",  32'(ifc.valor_binario), 32'hFF);
    chk("dec 255 pronto", 32'(ifc.pronto), 32'd1);
    chk("model 255",      32'(m_valor), 32'hFF);
    ocioso();
    chk("pronto one cycle", 32'(ifc.pronto), 32'd0);

    // Decimal 256 overflows
    dig(4'd2, 2'b00); dig(4'd5, 2'b00); dig(4'd6, 2'b00);
    chk("dec 256 erro", 32'(ifc.erro), 32'd1);
    conf();
    chk("erro conf ignored pronto", 32'(ifc.pronto), 32'd0);
    chk("erro keeps valor", 32'(ifc.valor_binario), 32'hFF);
    limpa();
    chk("limpar clears erro", 32'(ifc.erro), 32'd0);

    // Hex A3, then a third hex digit
    dig(4'hA, 2'b01); dig(4'h3, 2'b01); conf();
    chk("hex A3", 32'(ifc.valor_binario), 32'hA3);
    dig(4'hA, 2'b01); dig(4'h3, 2'b01); dig(4'h1, 2'b01);
    chk("hex third digit erro", 32'(ifc.erro), 32'd1);
    limpa();

    // Octal 377 with base changed mid-entry
    dig(4'd3, 2'b10); dig(4'd7, 2'b01); dig(4'd7, 2'b01); conf();
    chk("oct 377", 32'(ifc.valor_binario), 32'hFF);
    dig(4'd8, 2'b10);
    chk("oct digit 8 erro", 32'(ifc.erro), 32'd1);
    limpa();

    // Simultaneous strobes
    dig(4'd1, 2'b00);
    ciclo(1'b1, 1'b0, 1'b1, 4'd3, 2'b00);
    chk("limpar+digit num", 32'(ifc.num_digitos), 32'd0);
    dig(4'd4, 2'b00);
    ciclo(1'b0, 1'b1, 1'b1, 4'd7, 2'b00);
    chk("conf+digit valor", 32'(ifc.valor_binario), 32'd4);

    // Reset mid-entry, then empty confirm
    dig(4'd1, 2'b00); dig(4'd2, 2'b00);
    reset = 1'b1;
    ocioso();
    reset = 1'b0;
    chk("reset mid num",   32'(ifc.num_digitos), 32'd0);
    chk("reset mid valor", 32'(ifc.valor_binario), 32'd0);
    conf();
    chk("empty conf pronto", 32'(ifc.pronto), 32'd1);
    chk("empty conf valor",  32'(ifc.valor_binario), 32'd0);

    // Random strobes
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] b;
      b = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      reset = ($urandom_range(0, 199) == 0);
      ciclo(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 0), 4'($urandom_range(0, 15)), b);
    end
    reset = 1'b0;
    ocioso();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
